// File: rtl/karatsuba_mac_seq.sv
// Sequential one-level Karatsuba multiplier with wrap-around accumulator.
// One (WIDTH/2+1)-bit multiplier is reused for z0, z2 and zm over three cycles.
module karatsuba_mac_seq #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 48
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  input  logic                   acc_clr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*WIDTH-1:0]     product,
  output logic [ACC_WIDTH-1:0]   acc,
  output logic                   ovf
);

  localparam int H   = WIDTH / 2;
  localparam int PW  = 2 * WIDTH;
  localparam int MW  = H + 1;
  localparam int ZW  = 2 * MW;
  localparam int AW1 = ACC_WIDTH + 1;

  typedef enum logic [2:0] {
    IDLE, P0, P2, PM, ACC, DONE
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] ra, rb;
  logic             rclr;
  logic [ZW-1:0]    z0, z2, zm;

  logic [MW-1:0]    ma, mb;
  logic [ZW-1:0]    mul;
  logic [ZW-1:0]    z1;
  logic [PW-1:0]    prod_c;
  logic [AW1-1:0]   sum;

  // Operand select for the single shared multiplier
  always_comb begin
    ma = '0;
    mb = '0;
    unique case (state)
      P0: begin
        ma = {1'b0, ra[H-1:0]};
        mb = {1'b0, rb[H-1:0]};
      end
      P2: begin
        ma = {1'b0, ra[WIDTH-1:H]};
        mb = {1'b0, rb[WIDTH-1:H]};
      end
      PM: begin
        ma = {1'b0, ra[WIDTH-1:H]} + {1'b0, ra[H-1:0]};
        mb = {1'b0, rb[WIDTH-1:H]} + {1'b0, rb[H-1:0]};
      end
      default: ;
    endcase
  end

  assign mul    = ZW'(ma) * ZW'(mb);
  assign z1     = zm - z2 - z0;
  assign prod_c = (PW'(z2) << WIDTH) + (PW'(z1) << H) + PW'(z0);
  assign sum    = {1'b0, acc} + AW1'(prod_c);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      product   <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
      ra        <= '0;
      rb        <= '0;
      rclr      <= 1'b0;
      z0        <= '0;
      z2        <= '0;
      zm        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            ra       <= a;
            rb       <= b;
            rclr     <= acc_clr;
            in_ready <= 1'b0;
            state    <= P0;
          end
        end
        P0: begin
          z0    <= mul;
          state <= P2;
        end
        P2: begin
          z2    <= mul;
          state <= PM;
        end
        PM: begin
          zm    <= mul;
          state <= ACC;
        end
        ACC: begin
          product <= prod_c;
          if (rclr) begin
            acc <= ACC_WIDTH'(prod_c);
            ovf <= 1'b0;
          end else begin
            acc <= sum[ACC_WIDTH-1:0];
            ovf <= ovf | sum[ACC_WIDTH];
          end
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_karatsuba_mac_seq.sv
// Directed and random checks of karatsuba_mac_seq at three parameter sets.
// All three instances share inputs; each phase checks the relevant one.
module tb_karatsuba_mac_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] a, b;
  logic        acc_clr;
  logic        out_ready;

  logic        rdy0, vld0, ovf0;
  logic [31:0] p0;
  logic [47:0] acc0;
  logic        rdy1, vld1, ovf1;
  logic [31:0] p1;
  logic [31:0] acc1;
  logic        rdy2, vld2, ovf2;
  logic [15:0] p2;
  logic [19:0] acc2;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  karatsuba_mac_seq #(.WIDTH(16), .ACC_WIDTH(48)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
    .a(a), .b(b), .acc_clr(acc_clr), .out_valid(vld0),
    .out_ready(out_ready), .product(p0), .acc(acc0), .ovf(ovf0)
  );

  karatsuba_mac_seq #(.WIDTH(16), .ACC_WIDTH(32)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .a(a), .b(b), .acc_clr(acc_clr), .out_valid(vld1),
    .out_ready(out_ready), .product(p1), .acc(acc1), .ovf(ovf1)
  );

  karatsuba_mac_seq #(.WIDTH(8), .ACC_WIDTH(20)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2),
    .a(a[7:0]), .b(b[7:0]), .acc_clr(acc_clr), .out_valid(vld2),
    .out_ready(out_ready), .product(p2), .acc(acc2), .ovf(ovf2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Offer one operand beat, then wait for out_valid; returns edges after accept
  task automatic beat(input logic [15:0] aa, input logic [15:0] bb,
                      input logic c, output int lat);
    int n;
    n = 0;
    while (!rdy0 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("wait_in_ready", {63'd0, rdy0}, 64'd1);
    in_valid = 1'b1;
    a        = aa;
    b        = bb;
    acc_clr  = c;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!vld0 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
  endtask

  int          lat;
  int          seen;
  logic [7:0]  ra8, rb8;
  logic        rc;
  logic [19:0] macc;
  logic        movf;
  logic [20:0] msum;
  logic [15:0] mprod;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    acc_clr   = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", {63'd0, rdy0}, 64'd1);
    chk("rst_out_valid", {63'd0, vld0}, 64'd0);
    chk("rst_product", {32'd0, p0}, 64'd0);
    chk("rst_acc", {16'd0, acc0}, 64'd0);
    chk("rst_ovf", {63'd0, ovf0}, 64'd0);

    // Basic and accumulate
    beat(16'd1234, 16'd4321, 1'b1, lat);
    chk("basic_latency", 64'(lat), 64'd4);
    chk("basic_product", {32'd0, p0}, 64'd5332114);
    chk("basic_acc", {16'd0, acc0}, 64'd5332114);
    chk("basic_ovf", {63'd0, ovf0}, 64'd0);
    consume();
    chk("after_hs_in_ready", {63'd0, rdy0}, 64'd1);
    chk("after_hs_out_valid", {63'd0, vld0}, 64'd0);

    beat(16'd1111, 16'd2222, 1'b0, lat);
    chk("accum_latency", 64'(lat), 64'd4);
    chk("accum_product", {32'd0, p0}, 64'd2468642);
    chk("accum_acc", {16'd0, acc0}, 64'd7800756);
    consume();

    // Overflow wrap on the 32-bit accumulator instance
    beat(16'hFFFF, 16'hFFFF, 1'b1, lat);
    chk("ovf1_product", {32'd0, p1}, 64'hFFFE0001);
    chk("ovf1_acc", {32'd0, acc1}, 64'hFFFE0001);
    chk("ovf1_flag", {63'd0, ovf1}, 64'd0);
    chk("max16_product_w48", {32'd0, p0}, 64'hFFFE0001);
    consume();
    beat(16'hFFFF, 16'hFFFF, 1'b0, lat);
    chk("ovf2_acc", {32'd0, acc1}, 64'hFFFC0002);
    chk("ovf2_flag", {63'd0, ovf1}, 64'd1);
    chk("w48_no_ovf", {63'd0, ovf0}, 64'd0);
    chk("w48_acc", {16'd0, acc0}, 64'h1FFFC0002);
    consume();
    beat(16'd0, 16'd0, 1'b0, lat);
    chk("ovf3_sticky", {63'd0, ovf1}, 64'd1);
    chk("ovf3_acc", {32'd0, acc1}, 64'hFFFC0002);
    chk("zero_product", {32'd0, p1}, 64'd0);
    consume();
    beat(16'd3, 16'd5, 1'b1, lat);
    chk("ovf4_clear", {63'd0, ovf1}, 64'd0);
    chk("ovf4_acc", {32'd0, acc1}, 64'd15);
    consume();

    // Back-pressure: hold DONE and wiggle inputs
    out_ready = 1'b0;
    beat(16'd300, 16'd7, 1'b1, lat);
    chk("bp_product", {32'd0, p0}, 64'd2100);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      a        = 16'(i * 17 + 3);
      tick();
      chk("bp_out_valid", {63'd0, vld0}, 64'd1);
      chk("bp_in_ready", {63'd0, rdy0}, 64'd0);
      chk("bp_product_hold", {32'd0, p0}, 64'd2100);
      chk("bp_acc_hold", {16'd0, acc0}, 64'd2100);
    end
    in_valid  = 1'b1;
    a         = 16'd50;
    b         = 16'd2;
    acc_clr   = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_hs_out_valid", {63'd0, vld0}, 64'd0);
    chk("bp_hs_in_ready", {63'd0, rdy0}, 64'd1);
    tick();
    chk("bp_accept_next", {63'd0, rdy0}, 64'd0);
    in_valid = 1'b0;
    lat = 0;
    while (!vld0 && lat < 20) begin
      tick();
      lat++;
    end
    chk("bp_next_latency", 64'(lat), 64'd4);
    chk("bp_next_product", {32'd0, p0}, 64'd100);
    chk("bp_next_acc", {16'd0, acc0}, 64'd2200);
    consume();

    // Reset while in PM discards the beat
    beat(16'd100, 16'd5, 1'b1, lat);
    chk("pre_rst_acc", {16'd0, acc0}, 64'd500);
    consume();
    in_valid = 1'b1;
    a        = 16'd100;
    b        = 16'd7;
    acc_clr  = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_in_ready", {63'd0, rdy0}, 64'd1);
    chk("midrst_out_valid", {63'd0, vld0}, 64'd0);
    chk("midrst_acc", {16'd0, acc0}, 64'd0);
    chk("midrst_ovf", {63'd0, ovf0}, 64'd0);
    chk("midrst_product", {32'd0, p0}, 64'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (vld0) seen++;
    end
    chk("midrst_no_result", 64'(seen), 64'd0);

    // Narrow instance: WIDTH=8, ACC_WIDTH=20
    beat(16'd200, 16'd255, 1'b1, lat);
    chk("w8_200x255", {48'd0, p2}, 64'd51000);
    consume();
    beat(16'd255, 16'd255, 1'b0, lat);
    chk("w8_255x255", {48'd0, p2}, 64'd65025);
    chk("w8_acc", {44'd0, acc2}, 64'd116025);
    chk("w8_ovf", {63'd0, ovf2}, 64'd0);
    consume();

    macc = 20'd116025;
    movf = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      ra8   = 8'($urandom_range(0, 255));
      rb8   = 8'($urandom_range(0, 255));
      rc    = ($urandom_range(0, 15) == 0);
      mprod = 16'(ra8) * 16'(rb8);
      if (rc) begin
        macc = 20'(mprod);
        movf = 1'b0;
      end else begin
        msum = 21'(macc) + 21'(mprod);
        macc = msum[19:0];
        movf = movf | msum[20];
      end
      beat({8'd0, ra8}, {8'd0, rb8}, rc, lat);
      chk("rand_product", {48'd0, p2}, {48'd0, mprod});
      chk("rand_acc", {44'd0, acc2}, {44'd0, macc});
      chk("rand_ovf", {63'd0, ovf2}, {63'd0, movf});
      consume();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
